// File: rtl/nap_countdown_if.sv
// Keypad-setting, control and display signals of the nap countdown timer.
// The master drives setting and control; the slave drives display and status.
interface nap_countdown_if;
    logic       completeSetting;
    logic [3:0] one_sec_in;
    logic [3:0] ten_sec_in;
    logic [3:0] one_min_in;
    logic       pause;
    logic       cancel;
    logic       ack;
    logic [3:0] one_sec;
    logic [3:0] ten_sec;
    logic [3:0] one_min;
    logic       running;
    logic       alarm;
    logic       done_pulse;

    modport master (
        output completeSetting, one_sec_in, ten_sec_in, one_min_in, pause, cancel, ack,
        input  one_sec, ten_sec, one_min, running, alarm, done_pulse
    );

    modport slave (
        input  completeSetting, one_sec_in, ten_sec_in, one_min_in, pause, cancel, ack,
        output one_sec, ten_sec, one_min, running, alarm, done_pulse
    );
endinterface

// File: rtl/nap_countdown.sv
// BCD m:ss nap timer: latches a keypad setting, counts it down one step per
// TICK_DIV clocks and raises a self-expiring alarm at 0:00.
//
// state | meaning
// IDLE  | waiting for a start strobe; display shows the shadowed setting
// RUN   | counting down; prescaler advancing
// PAUSE | countdown and prescaler frozen while pause is high
// ALARM | reached 0:00; alarm held until ack, cancel or ALARM_SECS ticks
module nap_countdown #(
    parameter int TICK_DIV   = 1000,
    parameter int ALARM_SECS = 10
) (
    input  logic          clock,
    input  logic          reset,
    nap_countdown_if.slave nap
);
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int AW = $clog2(ALARM_SECS + 1);
    localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
    localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SECS - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_t;

    state_t        state, state_nx;
    logic [11:0]   shadow, shadow_nx;
    logic [11:0]   counter, counter_nx;
    logic [PW-1:0] prescaler, prescaler_nx;
    logic [AW-1:0] alarm_cnt, alarm_cnt_nx;
    logic          enter_alarm;
    logic          tick;
    logic [11:0]   disp_q, disp_d;
    logic          running_q, running_d;
    logic          alarm_q, alarm_d;
    logic          done_q, done_d;
    logic          inputs_valid, inputs_nonzero;

    function automatic logic [11:0] bcd_dec(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v[3:0] != 4'd0) begin
            r[3:0] = v[3:0] - 4'd1;
        end else if (v[7:4] != 4'd0) begin
            r[7:4] = v[7:4] - 4'd1;
            r[3:0] = 4'd9;
        end else if (v[11:8] != 4'd0) begin
            r[11:8] = v[11:8] - 4'd1;
            r[7:4]  = 4'd5;
            r[3:0]  = 4'd9;
        end
        return r;
    endfunction

    assign inputs_valid   = (nap.one_sec_in <= 4'd9) && (nap.ten_sec_in <= 4'd5) &&
                            (nap.one_min_in <= 4'd9);
    assign inputs_nonzero = |{nap.one_min_in, nap.ten_sec_in, nap.one_sec_in};
    assign shadow_nx      = (inputs_valid && inputs_nonzero) ?
                            {nap.one_min_in, nap.ten_sec_in, nap.one_sec_in} : shadow;
    assign tick           = (prescaler == PRE_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shadow    <= '0;
            counter   <= '0;
            prescaler <= '0;
            alarm_cnt <= '0;
            disp_q    <= '0;
            running_q <= 1'b0;
            alarm_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_nx;
            shadow    <= shadow_nx;
            counter   <= counter_nx;
            prescaler <= prescaler_nx;
            alarm_cnt <= alarm_cnt_nx;
            disp_q    <= disp_d;
            running_q <= running_d;
            alarm_q   <= alarm_d;
            done_q    <= done_d;
        end
    end

    // A pause-release edge counts as a running cycle, so the nap is stretched
    // by exactly the number of cycles spent paused.
    always_comb begin
        state_nx     = state;
        counter_nx   = counter;
        prescaler_nx = prescaler;
        alarm_cnt_nx = alarm_cnt;
        enter_alarm  = 1'b0;
        case (state)
            IDLE: begin
                if (nap.completeSetting && (shadow != 12'h000)) begin
                    state_nx     = RUN;
                    counter_nx   = shadow;
                    prescaler_nx = '0;
                end
            end
            RUN, PAUSE: begin
                if (nap.cancel) begin
                    state_nx   = IDLE;
                    counter_nx = '0;
                end else if (nap.pause) begin
                    state_nx = PAUSE;
                end else begin
                    state_nx = RUN;
                    if (tick) begin
                        prescaler_nx = '0;
                        if (counter == 12'h001) begin
                            state_nx     = ALARM;
                            counter_nx   = '0;
                            alarm_cnt_nx = '0;
                            enter_alarm  = 1'b1;
                        end else begin
                            counter_nx = bcd_dec(counter);
                        end
                    end else begin
                        prescaler_nx = prescaler + 1'b1;
                    end
                end
            end
            ALARM: begin
                if (nap.cancel || nap.ack) begin
                    state_nx   = IDLE;
                    counter_nx = '0;
                end else if (tick) begin
                    prescaler_nx = '0;
                    if (alarm_cnt == ALARM_LAST) begin
                        state_nx   = IDLE;
                        counter_nx = '0;
                    end else begin
                        alarm_cnt_nx = alarm_cnt + 1'b1;
                    end
                end else begin
                    prescaler_nx = prescaler + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        disp_d    = (state_nx == IDLE) ? shadow_nx : counter_nx;
        running_d = (state_nx == RUN) || (state_nx == PAUSE);
        alarm_d   = (state_nx == ALARM);
        done_d    = enter_alarm;
    end

    assign nap.one_min    = disp_q[11:8];
    assign nap.ten_sec    = disp_q[7:4];
    assign nap.one_sec    = disp_q[3:0];
    assign nap.running    = running_q;
    assign nap.alarm      = alarm_q;
    assign nap.done_pulse = done_q;
endmodule

// File: tb/tb_nap_countdown.sv
// Scoreboard bench for nap_countdown: expected display/status words are queued
// against an edge number when stimulus is driven and compared on the falling edge.
module tb_nap_countdown;
    localparam int TD = 4;
    localparam int AS = 3;

    typedef struct {
        int          cyc;
        string       tag;
        logic [14:0] v;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   n;
    int   a;
    exp_t sb[$];
    exp_t e;
    logic [14:0] obs;

    nap_countdown_if nap();

    nap_countdown #(.TICK_DIV(TD), .ALARM_SECS(AS)) dut (
        .clock (clock),
        .reset (reset),
        .nap   (nap)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    assign obs = {nap.one_min, nap.ten_sec, nap.one_sec, nap.running, nap.alarm, nap.done_pulse};

    task automatic chk(input string tag, input logic [14:0] act, input logic [14:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at edge %0d: got %h want %h (min,ten,sec,run,alarm,done)",
                     tag, cyc, act, exp);
        end
    endtask

    function automatic logic [14:0] ov(input int m, input int t, input int s,
                                       input bit r, input bit al, input bit d);
        return {4'(m), 4'(t), 4'(s), r, al, d};
    endfunction

    task automatic push(input int c, input string tag, input logic [14:0] v);
        exp_t x;
        x.cyc = c;
        x.tag = tag;
        x.v   = v;
        sb.push_back(x);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clock);
    endtask

    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            chk(e.tag, obs, e.v);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, edge %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        nap.completeSetting = 1'b0;
        nap.one_sec_in = 4'd0;
        nap.ten_sec_in = 4'd0;
        nap.one_min_in = 4'd0;
        nap.pause = 1'b0;
        nap.cancel = 1'b0;
        nap.ack = 1'b0;

        @(negedge clock);
        @(negedge clock);
        push(cyc + 1, "reset", ov(0, 0, 0, 0, 0, 0));
        @(negedge clock);
        reset = 1'b0;

        // 0:05 nap, alarm and one-cycle done pulse, ack back to IDLE
        @(negedge clock);
        nap.one_sec_in = 4'd5;
        push(cyc + 1, "t1_shadow", ov(0, 0, 5, 0, 0, 0));
        @(negedge clock);
        nap.one_sec_in = 4'd0;
        nap.completeSetting = 1'b1;
        n = cyc + 1;
        push(n,      "t1_load",      ov(0, 0, 5, 1, 0, 0));
        push(n + 4,  "t1_dec",       ov(0, 0, 4, 1, 0, 0));
        push(n + 19, "t1_last",      ov(0, 0, 1, 1, 0, 0));
        push(n + 20, "t1_alarm",     ov(0, 0, 0, 0, 1, 1));
        push(n + 21, "t1_pulse_end", ov(0, 0, 0, 0, 1, 0));
        push(n + 22, "t1_ack",       ov(0, 0, 5, 0, 0, 0));
        @(negedge clock);
        nap.completeSetting = 1'b0;
        wait_until(n + 21);
        nap.ack = 1'b1;
        @(negedge clock);
        nap.ack = 1'b0;

        // 1:00 with minute and tens borrows, cancel late
        @(negedge clock);
        nap.one_min_in = 4'd1;
        push(cyc + 1, "t2_shadow", ov(1, 0, 0, 0, 0, 0));
        @(negedge clock);
        nap.one_min_in = 4'd0;
        nap.completeSetting = 1'b1;
        n = cyc + 1;
        push(n,      "t2_load",   ov(1, 0, 0, 1, 0, 0));
        push(n + 4,  "t2_059",    ov(0, 5, 9, 1, 0, 0));
        push(n + 8,  "t2_058",    ov(0, 5, 8, 1, 0, 0));
        push(n + 40, "t2_050",    ov(0, 5, 0, 1, 0, 0));
        push(n + 44, "t2_049",    ov(0, 4, 9, 1, 0, 0));
        push(n + 46, "t2_cancel", ov(1, 0, 0, 0, 0, 0));
        @(negedge clock);
        nap.completeSetting = 1'b0;
        wait_until(n + 45);
        nap.cancel = 1'b1;
        @(negedge clock);
        nap.cancel = 1'b0;

        // 0:05 with 10 paused cycles; alarm expires on its own
        @(negedge clock);
        nap.one_sec_in = 4'd5;
        push(cyc + 1, "t3_shadow", ov(0, 0, 5, 0, 0, 0));
        @(negedge clock);
        nap.one_sec_in = 4'd0;
        nap.completeSetting = 1'b1;
        n = cyc + 1;
        push(n,      "t3_load",      ov(0, 0, 5, 1, 0, 0));
        push(n + 4,  "t3_dec",       ov(0, 0, 4, 1, 0, 0));
        push(n + 7,  "t3_paused",    ov(0, 0, 4, 1, 0, 0));
        push(n + 16, "t3_frozen",    ov(0, 0, 4, 1, 0, 0));
        push(n + 17, "t3_resume",    ov(0, 0, 4, 1, 0, 0));
        push(n + 18, "t3_dec2",      ov(0, 0, 3, 1, 0, 0));
        push(n + 29, "t3_last",      ov(0, 0, 1, 1, 0, 0));
        push(n + 30, "t3_alarm",     ov(0, 0, 0, 0, 1, 1));
        push(n + 41, "t4_alarm_hold", ov(0, 0, 0, 0, 1, 0));
        push(n + 42, "t4_expire",    ov(0, 0, 5, 0, 0, 0));
        @(negedge clock);
        nap.completeSetting = 1'b0;
        wait_until(n + 6);
        nap.pause = 1'b1;
        wait_until(n + 10);
        nap.completeSetting = 1'b1;
        @(negedge clock);
        nap.completeSetting = 1'b0;
        wait_until(n + 16);
        nap.pause = 1'b0;
        wait_until(n + 42);

        // restart from retained shadow, ack two edges into ALARM
        @(negedge clock);
        nap.completeSetting = 1'b1;
        n = cyc + 1;
        a = n + 20;
        push(n,     "t4_restart", ov(0, 0, 5, 1, 0, 0));
        push(a,     "t4_alarm2",  ov(0, 0, 0, 0, 1, 1));
        push(a + 1, "t4_alarm2b", ov(0, 0, 0, 0, 1, 0));
        push(a + 2, "t4_ack",     ov(0, 0, 5, 0, 0, 0));
        @(negedge clock);
        nap.completeSetting = 1'b0;
        wait_until(a + 1);
        nap.ack = 1'b1;
        @(negedge clock);
        nap.ack = 1'b0;

        // cancel at 0:03
        @(negedge clock);
        nap.completeSetting = 1'b1;
        n = cyc + 1;
        push(n + 8,  "t6_003",    ov(0, 0, 3, 1, 0, 0));
        push(n + 10, "t6_cancel", ov(0, 0, 5, 0, 0, 0));
        @(negedge clock);
        nap.completeSetting = 1'b0;
        wait_until(n + 9);
        nap.cancel = 1'b1;
        @(negedge clock);
        nap.cancel = 1'b0;

        // maximum setting 9:59, then asynchronous reset mid-run
        @(negedge clock);
        nap.one_min_in = 4'd9;
        nap.ten_sec_in = 4'd5;
        nap.one_sec_in = 4'd9;
        push(cyc + 1, "max_shadow", ov(9, 5, 9, 0, 0, 0));
        @(negedge clock);
        nap.one_min_in = 4'd0;
        nap.ten_sec_in = 4'd0;
        nap.one_sec_in = 4'd0;
        nap.completeSetting = 1'b1;
        n = cyc + 1;
        push(n,     "max_load", ov(9, 5, 9, 1, 0, 0));
        push(n + 4, "max_dec",  ov(9, 5, 8, 1, 0, 0));
        @(negedge clock);
        nap.completeSetting = 1'b0;
        wait_until(n + 6);
        #2 reset = 1'b1;
        #1 chk("t6_async_rst", obs, ov(0, 0, 0, 0, 0, 0));
        @(negedge clock);
        reset = 1'b0;

        // zero shadow start is ignored; invalid digits never load
        @(negedge clock);
        nap.completeSetting = 1'b1;
        push(cyc + 1, "t5_zero_start", ov(0, 0, 0, 0, 0, 0));
        @(negedge clock);
        nap.completeSetting = 1'b0;
        nap.ten_sec_in = 4'd7;
        nap.one_sec_in = 4'd3;
        push(cyc + 1, "t5_bad_tens", ov(0, 0, 0, 0, 0, 0));
        @(negedge clock);
        nap.ten_sec_in = 4'd0;
        nap.one_sec_in = 4'd0;
        nap.one_min_in = 4'd10;
        push(cyc + 1, "t5_bad_min", ov(0, 0, 0, 0, 0, 0));
        @(negedge clock);
        nap.one_min_in = 4'd0;
        nap.ten_sec_in = 4'd5;
        push(cyc + 1, "t5_good", ov(0, 5, 0, 0, 0, 0));
        @(negedge clock);
        nap.ten_sec_in = 4'd0;
        push(cyc + 1, "t5_hold", ov(0, 5, 0, 0, 0, 0));
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);

        while (sb.size() > 0) begin
            e = sb.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL %s: expectation for edge %0d never checked", e.tag, e.cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
